// File: rtl/hex_tx_formatter_if.sv
// Handshake bundle between the monitor capture side, the hex formatter
// and the RS-232 transmitter.
//  - master: drives bytes in and plays the transmitter (busy).
//  - slave : the formatter itself.
interface hex_tx_formatter_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_eol;
    logic       in_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (
        output in_valid, in_data, in_eol, tx_busy,
        input  in_ready, tx_start, tx_data
    );

    modport slave (
        input  in_valid, in_data, in_eol, tx_busy,
        output in_ready, tx_start, tx_data
    );
endinterface

// File: rtl/hex_tx_formatter.sv
// Hex formatter for the TWI monitor: queues captured bytes in a small FIFO
// and feeds the serial transmitter one ASCII character at a time as
// "HL " per byte, with CR LF after an end-of-line byte or a full line.
module hex_tx_formatter #(
    parameter int DEPTH    = 8,
    parameter int LINE_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hex_tx_formatter_if.slave      bus,
    input  logic                   ovf_clr,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, HI, LO, SEP, CR, LF} state_t;

    logic [8:0]    mem [DEPTH];
    logic [8:0]    head_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          overflow_reg;

    state_t        state_reg;
    state_t        state_next;
    logic          send_reg;
    logic          send_next;
    logic          seen_busy_reg;
    logic          seen_busy_next;
    logic [7:0]    line_cnt_reg;
    logic [7:0]    line_cnt_next;
    logic [7:0]    tx_hold_reg;
    logic [7:0]    char_cur;

    logic          push;
    logic          drop;
    logic          pop;
    logic          start;
    logic          line_full;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n - 4'd10});
    endfunction

    assign push  = bus.in_valid && (count_reg != FULL);
    assign drop  = bus.in_valid && (count_reg == FULL);
    // Popping only from IDLE with the line quiet keeps a character that
    // survived a reset of this block from being overrun.
    assign pop   = (state_reg == IDLE) && (count_reg != '0) && !bus.tx_busy;
    assign start = (state_reg != IDLE) && send_reg;

    assign line_full = (9'(line_cnt_reg) + 9'd1) == 9'(LINE_LEN);

    assign bus.in_ready = (count_reg != FULL);
    assign bus.tx_start = start;
    assign bus.tx_data  = start ? char_cur : tx_hold_reg;
    assign overflow     = overflow_reg;
    assign fifo_count   = count_reg;

    // FIFO storage and registered head read into the holding register
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {bus.in_eol, bus.in_data};
        end
        if (pop) begin
            head_reg <= mem[rd_ptr_reg];
        end
    end

    // FIFO pointers, occupancy and sticky overflow (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Sequencer state, phase flags, line position and last character sent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            send_reg      <= 1'b0;
            seen_busy_reg <= 1'b0;
            line_cnt_reg  <= 8'd0;
            tx_hold_reg   <= 8'h00;
        end else begin
            state_reg     <= state_next;
            send_reg      <= send_next;
            seen_busy_reg <= seen_busy_next;
            line_cnt_reg  <= line_cnt_next;
            if (start) begin
                tx_hold_reg <= char_cur;
            end
        end
    end

    // Character belonging to the current state
    always_comb begin
        char_cur = tx_hold_reg;
        case (state_reg)
            HI:      char_cur = hex_char(head_reg[7:4]);
            LO:      char_cur = hex_char(head_reg[3:0]);
            SEP:     char_cur = 8'h20;
            CR:      char_cur = 8'h0D;
            LF:      char_cur = 8'h0A;
            default: char_cur = tx_hold_reg;
        endcase
    end

    // Next state: one SEND cycle per character, then WAIT until the
    // transmitter has been seen busy and has gone idle again
    always_comb begin
        state_next     = state_reg;
        send_next      = send_reg;
        seen_busy_next = seen_busy_reg;
        line_cnt_next  = line_cnt_reg;
        if (state_reg == IDLE) begin
            send_next = 1'b0;
            if (pop) begin
                state_next = HI;
                send_next  = 1'b1;
            end
        end else if (send_reg) begin
            send_next      = 1'b0;
            seen_busy_next = 1'b0;
        end else begin
            if (bus.tx_busy) begin
                seen_busy_next = 1'b1;
            end
            if (seen_busy_reg && !bus.tx_busy) begin
                send_next = 1'b1;
                case (state_reg)
                    HI:  state_next = LO;
                    LO:  state_next = (head_reg[8] || line_full) ? CR : SEP;
                    SEP: begin
                        state_next    = IDLE;
                        send_next     = 1'b0;
                        line_cnt_next = line_cnt_reg + 8'd1;
                    end
                    CR:  state_next = LF;
                    LF:  begin
                        state_next    = IDLE;
                        send_next     = 1'b0;
                        line_cnt_next = 8'd0;
                    end
                    default: begin
                        state_next = IDLE;
                        send_next  = 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hex_tx_formatter.sv
// Bench for hex_tx_formatter: two instances (LINE_LEN 16 and 2) share the
// byte stream, each with its own transmitter model and character scoreboard.
module tb_hex_tx_formatter;
    localparam int DEPTH = 8;
    localparam int NI    = 2;
    localparam int QSZ   = 4096;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       in_valid   = 1'b0;
    logic       in_eol     = 1'b0;
    logic [7:0] in_data    = 8'h00;
    logic       ovf_clr    = 1'b0;
    logic       force_busy = 1'b0;
    int         lat_cfg    = 1;
    int         dur_cfg    = 10;
    bit         rand_busy  = 1'b0;

    logic       start_w [NI];
    logic [7:0] data_w  [NI];
    logic       rdy_w   [NI];
    logic       ovf_w   [NI];
    logic       busy_w  [NI];
    logic [3:0] cnt_w   [NI];
    int         starts_w[NI];
    int         rd_w    [NI];
    int         hi_w    [NI];
    bit         act_w   [NI];

    // expected character streams; bit 8 marks the first character of a byte
    logic [8:0] exp_mem [NI][QSZ];
    int         exp_wr  [NI];
    int         line_m  [NI];
    int         pushed_n = 0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int line_len(input int i);
        return (i == 0) ? 16 : 2;
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        string digits;
        digits = "0123456789ABCDEF";
        return digits[n];
    endfunction

    task automatic append(input int i, input logic [8:0] v);
        exp_mem[i][exp_wr[i] % QSZ] = v;
        exp_wr[i]++;
    endtask

    // Reference: every accepted byte becomes hi, lo, then space or CR LF
    task automatic model_push(input logic [7:0] d, input logic e);
        for (int i = 0; i < NI; i++) begin
            append(i, {1'b1, hex_ascii(d[7:4])});
            append(i, {1'b0, hex_ascii(d[3:0])});
            if (e || (line_m[i] + 1 == line_len(i))) begin
                append(i, {1'b0, 8'h0D});
                append(i, {1'b0, 8'h0A});
                line_m[i] = 0;
            end else begin
                append(i, {1'b0, 8'h20});
                line_m[i]++;
            end
        end
        pushed_n++;
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g
        hex_tx_formatter_if bus ();
        bit         active    = 1'b0;
        int         k         = 0;
        int         cur_lat   = 1;
        int         cur_dur   = 1;
        logic       start_smp = 1'b0;
        logic       model_busy;
        int         exp_rd    = 0;
        int         hi_seen   = 0;
        int         starts    = 0;
        logic [7:0] held      = 8'h00;
        logic       ovf;
        logic [3:0] cnt;

        assign model_busy   = active && (k >= cur_lat) && (k < cur_lat + cur_dur);
        assign bus.in_valid = in_valid;
        assign bus.in_data  = in_data;
        assign bus.in_eol   = in_eol;
        assign bus.tx_busy  = force_busy | model_busy;

        assign start_w[gi]  = bus.tx_start;
        assign data_w[gi]   = bus.tx_data;
        assign rdy_w[gi]    = bus.in_ready;
        assign busy_w[gi]   = bus.tx_busy;
        assign ovf_w[gi]    = ovf;
        assign cnt_w[gi]    = cnt;
        assign starts_w[gi] = starts;
        assign rd_w[gi]     = exp_rd;
        assign hi_w[gi]     = hi_seen;
        assign act_w[gi]    = active;

        hex_tx_formatter #(.DEPTH(DEPTH), .LINE_LEN((gi == 0) ? 16 : 2)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .bus        (bus),
            .ovf_clr    (ovf_clr),
            .overflow   (ovf),
            .fifo_count (cnt)
        );

        // transmitter: busy rises cur_lat cycles after start, lasts cur_dur
        always @(posedge clk) begin
            if (start_smp) begin
                active  <= 1'b1;
                k       <= 1;
                cur_lat <= rand_busy ? int'($urandom_range(1, 2)) : lat_cfg;
                cur_dur <= rand_busy ? int'($urandom_range(1, 6)) : dur_cfg;
            end else if (active) begin
                if (k >= cur_lat + cur_dur - 1) active <= 1'b0;
                k <= k + 1;
            end
        end

        // character scoreboard, sampled mid-cycle
        always @(negedge clk) begin
            start_smp <= bus.tx_start;
            if (!rst_n) begin
                exp_rd  <= exp_wr[gi];
                hi_seen <= pushed_n;
                held    <= 8'h00;
                check($sformatf("i%0d rst_tx_start", gi), bus.tx_start, 1'b0);
            end else if (bus.tx_start) begin
                starts <= starts + 1;
                check($sformatf("i%0d busy_at_start", gi), bus.tx_busy, 1'b0);
                check($sformatf("i%0d double_start", gi), bus.tx_start & active, 1'b0);
                if (exp_rd == exp_wr[gi]) begin
                    check($sformatf("i%0d spurious_start", gi), bus.tx_start, 1'b0);
                end else begin
                    check($sformatf("i%0d tx_data", gi), bus.tx_data, exp_mem[gi][exp_rd % QSZ][7:0]);
                    held <= exp_mem[gi][exp_rd % QSZ][7:0];
                    if (exp_mem[gi][exp_rd % QSZ][8]) hi_seen <= hi_seen + 1;
                    exp_rd <= exp_rd + 1;
                end
            end else begin
                check($sformatf("i%0d tx_data_hold", gi), bus.tx_data, held);
            end
        end
    end

    // one-cycle push, called and returning at a negedge
    task automatic drive_push(input logic [7:0] d, input logic e, input bit acc);
        in_valid = 1'b1;
        in_data  = d;
        in_eol   = e;
        @(posedge clk);
        if (acc) model_push(d, e);
        $display("push data=%02h eol=%0d %s", d, e, acc ? "accepted" : "dropped");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < NI; i++) line_m[i] = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
            done = (rd_w[0] == exp_wr[0]) && (rd_w[1] == exp_wr[1]) && !act_w[0] && !act_w[1];
        end
        check("drain", done, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_flags(input string tag, input logic ovf_e, input logic [3:0] cnt_e, input logic rdy_e);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s i%0d overflow", tag, i), ovf_w[i], ovf_e);
            check($sformatf("%s i%0d fifo_count", tag, i), cnt_w[i], cnt_e);
            check($sformatf("%s i%0d in_ready", tag, i), rdy_w[i], rdy_e);
        end
    endtask

    int base [NI];
    int wbase[NI];

    initial begin
        bit reached;
        for (int i = 0; i < NI; i++) begin
            exp_wr[i] = 0;
            line_m[i] = 0;
        end

        // reset values
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset i%0d tx_start", i), start_w[i], 1'b0);
            check($sformatf("reset i%0d tx_data", i), data_w[i], 8'h00);
        end
        check_flags("reset", 1'b0, 4'd0, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // single byte 3C, minimum latency
        for (int i = 0; i < NI; i++) base[i] = starts_w[i];
        drive_push(8'h3C, 1'b0, 1'b1);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("lat_n1 i%0d tx_start", i), start_w[i], 1'b0);
            check($sformatf("lat_n1 i%0d fifo_count", i), cnt_w[i], 4'd1);
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("lat_n2 i%0d tx_start", i), start_w[i], 1'b1);
            check($sformatf("lat_n2 i%0d fifo_count", i), cnt_w[i], 4'd0);
        end
        wait_drain();
        check("3C i0 starts", starts_w[0] - base[0], 3);
        check("3C i1 starts", starts_w[1] - base[1], 3);

        // A5 then 0F: line wrap on the LINE_LEN=2 instance
        do_reset();
        for (int i = 0; i < NI; i++) base[i] = starts_w[i];
        drive_push(8'hA5, 1'b0, 1'b1);
        drive_push(8'h0F, 1'b0, 1'b1);
        wait_drain();
        check("A50F i0 starts", starts_w[0] - base[0], 6);
        check("A50F i1 starts", starts_w[1] - base[1], 7);

        // FF with eol: no separator
        do_reset();
        for (int i = 0; i < NI; i++) base[i] = starts_w[i];
        drive_push(8'hFF, 1'b1, 1'b1);
        wait_drain();
        check("FFeol i0 starts", starts_w[0] - base[0], 4);
        check("FFeol i1 starts", starts_w[1] - base[1], 4);

        // overflow with the transmitter held busy
        do_reset();
        force_busy = 1'b1;
        for (int i = 0; i < NI; i++) base[i] = starts_w[i];
        for (int b = 0; b < DEPTH; b++) drive_push(8'(b), 1'b0, 1'b1);
        check_flags("full", 1'b0, 4'd8, 1'b0);
        drive_push(8'h08, 1'b0, 1'b0);
        check_flags("dropped", 1'b1, 4'd8, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h09;
        ovf_clr  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        ovf_clr  = 1'b0;
        check_flags("set_wins", 1'b1, 4'd8, 1'b0);
        force_busy = 1'b0;
        wait_drain();
        check("ovf i0 starts", starts_w[0] - base[0], 24);
        check("ovf i1 starts", starts_w[1] - base[1], 28);
        check_flags("drained", 1'b1, 4'd0, 1'b1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check_flags("ovf_clr", 1'b0, 4'd0, 1'b1);

        // late busy: rises two cycles after start
        do_reset();
        lat_cfg = 2;
        dur_cfg = 4;
        for (int i = 0; i < NI; i++) base[i] = starts_w[i];
        for (int b = 0; b < 3; b++) drive_push(8'($urandom_range(0, 255)), 1'b0, 1'b1);
        wait_drain();
        check("late i0 starts", starts_w[0] - base[0], 9);
        check("late i1 starts", starts_w[1] - base[1], 10);
        lat_cfg = 1;
        dur_cfg = 10;

        // reset while the low nibble is on the wire, three bytes queued
        do_reset();
        for (int i = 0; i < NI; i++) base[i] = starts_w[i];
        drive_push(8'h11, 1'b0, 1'b1);
        drive_push(8'h22, 1'b0, 1'b1);
        drive_push(8'h33, 1'b0, 1'b1);
        drive_push(8'h44, 1'b0, 1'b1);
        reached = 1'b0;
        for (int n = 0; n < 200 && !reached; n++) begin
            if (starts_w[0] - base[0] == 2) reached = 1'b1;
            else @(negedge clk);
        end
        check("reach_lo", reached, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        for (int i = 0; i < NI; i++) line_m[i] = 0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("async_rst i%0d tx_start", i), start_w[i], 1'b0);
            check($sformatf("async_rst i%0d tx_data", i), data_w[i], 8'h00);
        end
        check_flags("async_rst", 1'b0, 4'd0, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) base[i] = starts_w[i];
        reached = 1'b0;
        for (int n = 0; n < 100 && !reached; n++) begin
            if (!busy_w[0] && !busy_w[1]) reached = 1'b1;
            else @(negedge clk);
        end
        check("busy_released", reached, 1'b1);
        repeat (10) @(negedge clk);
        check("post_rst i0 silent", starts_w[0] - base[0], 0);
        check("post_rst i1 silent", starts_w[1] - base[1], 0);
        drive_push(8'h5A, 1'b0, 1'b1);
        wait_drain();
        check("post_rst i0 starts", starts_w[0] - base[0], 3);
        check("post_rst i1 starts", starts_w[1] - base[1], 3);

        // randomized traffic with randomized transmitter timing
        do_reset();
        rand_busy = 1'b1;
        for (int i = 0; i < NI; i++) wbase[i] = exp_wr[i];
        for (int i = 0; i < NI; i++) base[i] = starts_w[i];
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0 && (pushed_n - hi_w[0] < DEPTH) && (pushed_n - hi_w[1] < DEPTH)) begin
                drive_push(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), 1'b1);
            end else begin
                ovf_clr = ($urandom_range(0, 7) == 0);
                @(negedge clk);
                ovf_clr = 1'b0;
            end
        end
        wait_drain();
        check("rand i0 starts", starts_w[0] - base[0], exp_wr[0] - wbase[0]);
        check("rand i1 starts", starts_w[1] - base[1], exp_wr[1] - wbase[1]);
        check_flags("rand_end", 1'b0, 4'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hex_tx_formatter.md
Name: hex_tx_formatter

Overview:
- Sits directly upstream of the RS-232 transmitter in the TWI monitor.
- Buffers captured monitor bytes in a small FIFO and renders each byte as two uppercase ASCII hex characters followed by a separator.
- Drives the transmitter's start/data/busy handshake one character at a time, so monitor capture never stalls on the serial line.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- LINE_LEN, 16, bytes per output line before an automatic CR LF; range 1..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  push request for in_data/in_eol.
- in_data  input  8  byte to be printed.
- in_eol  input  1  force CR LF after this byte.
- in_ready  output  1  FIFO not full; combinational from the count.
- ovf_clr  input  1  clears overflow.
- overflow  output  1  sticky; set when a push is dropped.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- tx_start  output  1  one-cycle pulse to the transmitter.
- tx_data  output  8  ASCII character; valid while tx_start is high and held afterwards.
- tx_busy  input  1  transmitter busy.

Behaviour:
- Reset (rst_n low, asynchronous)
  - FSM goes to IDLE; FIFO is emptied; line counter is 0.
  - Outputs: tx_start=0, tx_data=8'h00, overflow=0, fifo_count=0, in_ready=1.
- FIFO
  - 9-bit entries: {eol, data}; registered pointers.
  - A push occurs when in_valid=1 and count<DEPTH.
  - When in_valid=1 and count==DEPTH, the byte is dropped and overflow is set the next cycle. This holds even if a pop happens in the same cycle.
  - A pop occurs only when the FSM leaves IDLE, and loads the head into the holding register {h_eol, h_data}.
  - A simultaneous push and pop leaves the count unchanged.
  - ovf_clr=1 clears overflow next cycle; if set and clear coincide, set wins.
- Character encoding
  - Nibble 0-9 maps to 8'h30+n; nibble A-F maps to 8'h41+(n-10).
  - Separator is 8'h20; CR is 8'h0D; LF is 8'h0A.
- FSM states: IDLE, HI, LO, SEP, CR, LF.
  - Each non-IDLE state has a SEND phase and a WAIT phase.
- IDLE
  - Condition: count>0 and tx_busy=0.
  - Action: pop the head and go to HI/SEND.
- SEND phase (one cycle)
  - tx_start=1; tx_data = the state's character.
  - Go to the WAIT phase; clear the seen_busy flag.
- WAIT phase
  - Set seen_busy when tx_busy=1.
  - Exit when seen_busy=1 and tx_busy=0.
  - tx_busy is never sampled in the SEND cycle. The seen_busy guard tolerates a transmitter whose busy rises 1 or 2 cycles after start.
- Transitions on WAIT exit
  - HI goes to LO.
  - LO goes to CR if h_eol=1 or line_cnt+1==LINE_LEN; otherwise it goes to SEP.
  - SEP goes to IDLE; line_cnt increments.
  - CR goes to LF.
  - LF goes to IDLE; line_cnt becomes 0.
- Line counter: 8 bits; never exceeds LINE_LEN-1; no wrap.
- Throughput
  - Minimum latency from push into an empty FIFO with an idle transmitter to tx_start is 2 cycles: push in cycle N, IDLE pops at N+1, HI/SEND pulses at N+2.
  - tx_start is never asserted while tx_busy=1 on entry from IDLE.
- Reset mid-character
  - The block returns to IDLE.
  - The transmitter has no reset and may finish its character; IDLE waits for tx_busy=0 before the next pop, so no character is corrupted.
- in_ready and fifo_count are unaffected by FSM state, except through pops.

Test Plan:
- Idle bench; push 8'h3C with eol=0 and LINE_LEN=16; busy model with 10-cycle characters:
  - Expect the tx_data sequence 8'h33, 8'h43, 8'h20, one tx_start per character.
  - Expect each tx_start only after busy has fallen; line_cnt ends at 1.
- LINE_LEN=2; push 8'hA5 then 8'h0F:
  - Expect 'A','5',' ','0','F',CR,LF.
  - Expect line_cnt 0 at the end.
- Push 8'hFF with eol=1:
  - Expect 'F','F',CR,LF; no space is emitted.
- Hold tx_busy=1; push DEPTH+1 bytes (8'h00..8'h08) in back-to-back cycles:
  - Expect in_ready=0 after 8 pushes (the first pop is blocked).
  - Expect overflow=1 at the 9th push; fifo_count=8.
  - Release busy: bytes 00..07 are printed; 08 is absent.
  - Pulse ovf_clr: overflow returns to 0.
- Busy model that raises busy 2 cycles after start:
  - Expect no double tx_start (seen_busy guard).
  - Expect exactly 3 starts per byte without eol.
- Assert rst_n=0 mid-LO/WAIT with 3 bytes queued:
  - Expect outputs at reset values immediately (asynchronous) and fifo_count=0.
  - After release, with busy still high from the earlier character, expect no tx_start until busy=0 and a new push occurs.
